// File: rtl/run_sequencer.sv
// Run sequencer: loads dat_mem, runs the core until done, then dumps a memory window.
// Optional RUN_TIMEOUT_EN macro bounds the RUN state to MAX_CYCLES cycles.
module run_sequencer #(
    parameter int AW         = 8,
    parameter int MAX_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] ld_count,
    input  logic [AW-1:0] dump_base,
    input  logic [AW-1:0] dump_len,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic          rd_valid,
    output logic [7:0]    rd_data,
    input  logic          rd_ready,
    output logic          core_reset,
    input  logic          core_done,
    output logic          mem_sel,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          busy,
    output logic          finished,
    output logic          timeout,
    output logic [15:0]   cycle_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DUMP,
        FIN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] index;
    logic [AW-1:0] ld_count_q;
    logic [AW-1:0] dump_base_q;
    logic [AW-1:0] dump_len_q;
    logic [15:0]   cycle_q;

    logic accept;
    logic ld_last;
    logic rd_last;
    logic done_seen;
    logic limit_hit;

    assign accept  = start && (state == IDLE || state == FIN);
    assign ld_last = (index == ld_count_q - AW'(1));
    assign rd_last = (index == dump_len_q - AW'(1));

    // The first RUN cycle is the only one with a zero count, so it
    // doubles as the "ignore core_done" marker while the core leaves reset.
    assign done_seen = (state == RUN) && (cycle_q != 16'd0) && core_done;

`ifdef RUN_TIMEOUT_EN
    logic timeout_q;

    assign limit_hit = (state == RUN) &&
                       (32'(cycle_q) + 32'd1 >= 32'(MAX_CYCLES));
    assign timeout   = timeout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else if (accept) begin
            timeout_q <= 1'b0;
        end else if (limit_hit && !done_seen) begin
            timeout_q <= 1'b1;
        end
    end
`else
    assign limit_hit = 1'b0;
    assign timeout   = 1'b0;
`endif

    assign cycle_count = cycle_q;
    assign rd_data     = mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, FIN: begin
                if (start) begin
                    state_nxt = (ld_count != '0) ? LOAD : RUN;
                end
            end
            LOAD: begin
                if (ld_valid && ld_last) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (done_seen || limit_hit) begin
                    state_nxt = (dump_len_q == '0) ? FIN : DUMP;
                end
            end
            DUMP: begin
                if (rd_ready && rd_last) begin
                    state_nxt = FIN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        core_reset = 1'b1;
        mem_sel    = 1'b1;
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 8'h00;
        ld_ready   = 1'b0;
        rd_valid   = 1'b0;
        busy       = 1'b0;
        finished   = 1'b0;
        unique case (state)
            LOAD: begin
                ld_ready  = 1'b1;
                mem_wr_en = ld_valid;
                mem_addr  = index;
                mem_wdata = ld_data;
                busy      = 1'b1;
            end
            RUN: begin
                core_reset = 1'b0;
                mem_sel    = 1'b0;
                busy       = 1'b1;
            end
            DUMP: begin
                rd_valid = 1'b1;
                mem_addr = dump_base_q + index;
                busy     = 1'b1;
            end
            FIN: begin
                finished = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index       <= '0;
            cycle_q     <= 16'd0;
            ld_count_q  <= '0;
            dump_base_q <= '0;
            dump_len_q  <= '0;
        end else if (accept) begin
            index       <= '0;
            cycle_q     <= 16'd0;
            ld_count_q  <= ld_count;
            dump_base_q <= dump_base;
            dump_len_q  <= dump_len;
        end else begin
            unique case (state)
                LOAD: begin
                    if (ld_valid) begin
                        index <= ld_last ? '0 : index + AW'(1);
                    end
                end
                RUN: begin
                    if (cycle_q != 16'hFFFF) begin
                        cycle_q <= cycle_q + 16'd1;
                    end
                end
                DUMP: begin
                    if (rd_ready) begin
                        index <= rd_last ? '0 : index + AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with a 256-byte dat_mem model.
module tb_run_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  ld_count = 8'h00;
    logic [7:0]  dump_base = 8'h00;
    logic [7:0]  dump_len = 8'h00;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = 8'h00;
    logic        ld_ready;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_ready = 1'b0;
    logic        core_reset;
    logic        core_done = 1'b0;
    logic        mem_sel;
    logic        mem_wr_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        finished;
    logic        timeout;
    logic [15:0] cycle_count;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;

    logic [7:0] mem [256];

    run_sequencer #(
        .AW(8),
        .MAX_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ld_count(ld_count),
        .dump_base(dump_base),
        .dump_len(dump_len),
        .ld_valid(ld_valid),
        .ld_data(ld_data),
        .ld_ready(ld_ready),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .rd_ready(rd_ready),
        .core_reset(core_reset),
        .core_done(core_done),
        .mem_sel(mem_sel),
        .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy(busy),
        .finished(finished),
        .timeout(timeout),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en && mem_sel) begin
            mem[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({core_reset, mem_sel, mem_wr_en, ld_ready, rd_valid, busy, finished, timeout}
            !== 8'b1100_0000) begin
            $display("FAIL reset_flags got=%b exp=11000000",
                     {core_reset, mem_sel, mem_wr_en, ld_ready, rd_valid, busy, finished, timeout});
            failures++;
        end
        checks++;
        if (mem_addr !== 8'h00 || mem_wdata !== 8'h00 || cycle_count !== 16'd0) begin
            $display("FAIL reset_vals addr=%h wdata=%h cc=%0d exp 0/0/0",
                     mem_addr, mem_wdata, cycle_count);
            failures++;
        end
        checks++;
        if (rd_data !== 8'hC0) begin
            $display("FAIL reset_rd_data got=%h exp=c0", rd_data);
            failures++;
        end
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic test_load_run_dump;
        logic [7:0] bytes_in [3];
        logic [7:0] exp_addr [4];
        logic [7:0] exp_data [4];
        bytes_in = '{8'h11, 8'h22, 8'h33};
        exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        exp_data = '{8'h3E, 8'h3F, 8'h11, 8'h22};
        start = 1'b1; ld_count = 8'd3; dump_base = 8'hFE; dump_len = 8'd4;
        ld_valid = 1'b1; ld_data = bytes_in[0];
        step();
        start = 1'b0; ld_count = 8'd0; dump_base = 8'h00; dump_len = 8'd0;
        settle();
        checks++;
        if (!(ld_ready && mem_wr_en && core_reset && busy) || mem_addr !== 8'h00
            || mem_wdata !== 8'h11) begin
            $display("FAIL load_beat0 rdy=%b we=%b addr=%h wd=%h exp 1/1/00/11",
                     ld_ready, mem_wr_en, mem_addr, mem_wdata);
            failures++;
        end
        for (int i = 1; i < 3; i++) begin
            step();
            ld_data = bytes_in[i];
            settle();
            checks++;
            if (mem_addr !== 8'(i) || mem_wr_en !== 1'b1 || core_reset !== 1'b1) begin
                $display("FAIL load_addr got=%h we=%b exp=%h", mem_addr, mem_wr_en, 8'(i));
                failures++;
            end
        end
        step();
        ld_valid = 1'b0;
        settle();
        checks++;
        if (core_reset !== 1'b0 || mem_sel !== 1'b0 || ld_ready !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL run_entry core_reset=%b mem_sel=%b exp 0/0", core_reset, mem_sel);
            failures++;
        end
        checks++;
        if (mem[0] !== 8'h11 || mem[1] !== 8'h22 || mem[2] !== 8'h33 || wr_count !== 3) begin
            $display("FAIL load_mem got=%h %h %h n=%0d exp 11 22 33 n=3",
                     mem[0], mem[1], mem[2], wr_count);
            failures++;
        end
        for (int k = 1; k < 10; k++) step();
        core_done = 1'b1;
        settle();
        checks++;
        if (cycle_count !== 16'd9 || core_reset !== 1'b0) begin
            $display("FAIL run_count10 got=%0d exp=9", cycle_count);
            failures++;
        end
        step();
        core_done = 1'b0;
        rd_ready = 1'b1;
        settle();
        checks++;
        if (cycle_count !== 16'd10) begin
            $display("FAIL dump_cycle_count got=%0d exp=10", cycle_count);
            failures++;
        end
        for (int b = 0; b < 4; b++) begin
            settle();
            checks++;
            if (rd_valid !== 1'b1 || mem_addr !== exp_addr[b] || rd_data !== exp_data[b]) begin
                $display("FAIL dump_beat%0d v=%b addr=%h data=%h exp addr=%h data=%h",
                         b, rd_valid, mem_addr, rd_data, exp_addr[b], exp_data[b]);
                failures++;
            end
            step();
        end
        settle();
        checks++;
        if (finished !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0 || core_reset !== 1'b1) begin
            $display("FAIL fin_state fin=%b busy=%b rv=%b exp 1/0/0", finished, busy, rd_valid);
            failures++;
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_throttle;
        int n;
        int nbeat;
        int wr0;
        start = 1'b1; ld_count = 8'd4; dump_base = 8'h00; dump_len = 8'd2;
        ld_valid = 1'b0;
        step();
        start = 1'b0;
        wr0 = wr_count;
        n = 0;
        nbeat = 0;
        while (core_reset && n < 20) begin
            ld_valid = (n % 2 == 0);
            ld_data = 8'h40 + 8'(nbeat);
            settle();
            if (ld_valid && ld_ready) nbeat++;
            step();
            n++;
        end
        ld_valid = 1'b0;
        checks++;
        if (n !== 7) begin
            $display("FAIL throttle_cycles got=%0d exp=7", n);
            failures++;
        end
        checks++;
        if (wr_count - wr0 !== 4 || mem[0] !== 8'h40 || mem[1] !== 8'h41
            || mem[2] !== 8'h42 || mem[3] !== 8'h43) begin
            $display("FAIL throttle_mem n=%0d got=%h %h %h %h exp n=4 40 41 42 43",
                     wr_count - wr0, mem[0], mem[1], mem[2], mem[3]);
            failures++;
        end
        core_done = 1'b1;
        step();
        settle();
        checks++;
        if (core_reset !== 1'b0 || cycle_count !== 16'd1) begin
            $display("FAIL done_first_cycle core_reset=%b cc=%0d exp 0/1",
                     core_reset, cycle_count);
            failures++;
        end
        step();
        core_done = 1'b0;
        for (int s = 0; s < 5; s++) begin
            settle();
            checks++;
            if (rd_valid !== 1'b1 || mem_addr !== 8'h00 || cycle_count !== 16'd2) begin
                $display("FAIL stall%0d rv=%b addr=%h cc=%0d exp 1/00/2",
                         s, rd_valid, mem_addr, cycle_count);
                failures++;
            end
            step();
        end
        rd_ready = 1'b1;
        settle();
        checks++;
        if (mem_addr !== 8'h00 || rd_data !== 8'h40) begin
            $display("FAIL throttle_dump0 addr=%h data=%h exp 00/40", mem_addr, rd_data);
            failures++;
        end
        step();
        settle();
        checks++;
        if (mem_addr !== 8'h01 || rd_data !== 8'h41 || rd_valid !== 1'b1) begin
            $display("FAIL throttle_dump1 addr=%h data=%h exp 01/41", mem_addr, rd_data);
            failures++;
        end
        step();
        settle();
        checks++;
        if (finished !== 1'b1) begin
            $display("FAIL throttle_fin got=%b exp=1", finished);
            failures++;
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_zero_len;
        start = 1'b1; ld_count = 8'd0; dump_len = 8'd0; dump_base = 8'h33;
        step();
        start = 1'b0;
        settle();
        checks++;
        if (core_reset !== 1'b0 || ld_ready !== 1'b0 || rd_valid !== 1'b0) begin
            $display("FAIL zero_run_entry cr=%b rdy=%b rv=%b exp 0/0/0",
                     core_reset, ld_ready, rd_valid);
            failures++;
        end
        start = 1'b1; ld_count = 8'd5;
        step();
        start = 1'b0;
        settle();
        checks++;
        if (core_reset !== 1'b0 || busy !== 1'b1 || ld_ready !== 1'b0
            || cycle_count !== 16'd1) begin
            $display("FAIL start_ignored cr=%b rdy=%b cc=%0d exp 0/0/1",
                     core_reset, ld_ready, cycle_count);
            failures++;
        end
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        settle();
        checks++;
        if (finished !== 1'b1 || rd_valid !== 1'b0 || cycle_count !== 16'd2) begin
            $display("FAIL zero_fin fin=%b rv=%b cc=%0d exp 1/0/2",
                     finished, rd_valid, cycle_count);
            failures++;
        end
    endtask

    task automatic test_limit;
        start = 1'b1; ld_count = 8'd0; dump_len = 8'd1; dump_base = 8'h10;
        step();
        start = 1'b0;
`ifdef RUN_TIMEOUT_EN
        for (int k = 1; k < 16; k++) step();
        checks++;
        if (core_reset !== 1'b0 || timeout !== 1'b0) begin
            $display("FAIL timeout_early cr=%b to=%b exp 0/0", core_reset, timeout);
            failures++;
        end
        step();
        settle();
        checks++;
        if (rd_valid !== 1'b1 || timeout !== 1'b1 || cycle_count !== 16'd16
            || mem_addr !== 8'h10) begin
            $display("FAIL timeout_dump rv=%b to=%b cc=%0d addr=%h exp 1/1/16/10",
                     rd_valid, timeout, cycle_count, mem_addr);
            failures++;
        end
        rd_ready = 1'b1;
        step();
        settle();
        checks++;
        if (finished !== 1'b1 || timeout !== 1'b1) begin
            $display("FAIL timeout_hold fin=%b to=%b exp 1/1", finished, timeout);
            failures++;
        end
`else
        for (int k = 0; k < 100; k++) step();
        checks++;
        if (core_reset !== 1'b0 || timeout !== 1'b0 || cycle_count !== 16'd100) begin
            $display("FAIL no_limit cr=%b to=%b cc=%0d exp 0/0/100",
                     core_reset, timeout, cycle_count);
            failures++;
        end
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        rd_ready = 1'b1;
        settle();
        checks++;
        if (rd_valid !== 1'b1 || mem_addr !== 8'h10 || rd_data !== 8'hD0) begin
            $display("FAIL no_limit_dump rv=%b addr=%h data=%h exp 1/10/d0",
                     rd_valid, mem_addr, rd_data);
            failures++;
        end
        step();
        settle();
        checks++;
        if (finished !== 1'b1 || timeout !== 1'b0) begin
            $display("FAIL no_limit_fin fin=%b to=%b exp 1/0", finished, timeout);
            failures++;
        end
`endif
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid_dump;
        int wr0;
        start = 1'b1; ld_count = 8'd2; dump_len = 8'd4; dump_base = 8'h00;
        ld_valid = 1'b1; ld_data = 8'h5A;
        step();
        start = 1'b0;
        step();
        ld_data = 8'h5B;
        step();
        ld_valid = 1'b0;
        core_done = 1'b1;
        step();
        step();
        core_done = 1'b0;
        rd_ready = 1'b1;
        settle();
        checks++;
        if (rd_valid !== 1'b1 || mem_addr !== 8'h00 || rd_data !== 8'h5A) begin
            $display("FAIL rst_dump0 rv=%b addr=%h data=%h exp 1/00/5a",
                     rd_valid, mem_addr, rd_data);
            failures++;
        end
        step();
        reset = 1'b0;
        settle();
        checks++;
        if ({core_reset, mem_sel, mem_wr_en, ld_ready, rd_valid, busy, finished}
            !== 7'b1100000) begin
            $display("FAIL rst_mid_flags got=%b exp=1100000",
                     {core_reset, mem_sel, mem_wr_en, ld_ready, rd_valid, busy, finished});
            failures++;
        end
        checks++;
        if (mem_addr !== 8'h00 || mem_wdata !== 8'h00 || rd_data !== 8'h5A
            || cycle_count !== 16'd0) begin
            $display("FAIL rst_mid_vals addr=%h wd=%h rd=%h cc=%0d exp 00/00/5a/0",
                     mem_addr, mem_wdata, rd_data, cycle_count);
            failures++;
        end
        wr0 = wr_count;
        step();
        reset = 1'b1;
        step();
        settle();
        checks++;
        if (busy !== 1'b0 || finished !== 1'b0 || rd_valid !== 1'b0 || wr_count !== wr0) begin
            $display("FAIL rst_after busy=%b fin=%b rv=%b wr=%0d exp 0/0/0/%0d",
                     busy, finished, rd_valid, wr_count, wr0);
            failures++;
        end
        rd_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hC0 ^ 8'(i);
        test_reset();
        test_load_run_dump();
        test_throttle();
        test_zero_len();
        test_limit();
        test_reset_mid_dump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 SHALL have parameter AW, default 8, dat_mem address width.
REQ-002 SHALL have parameter MAX_CYCLES, default 4096, RUN-state cycle limit (used only with RUN_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-005 SHALL have ports start  input  1  run request; ld_count  input  AW  bytes to load; dump_base  input  AW  first dump address; dump_len  input  AW  bytes to dump.
REQ-006 SHALL have load stream ports ld_valid  input  1; ld_data  input  8; ld_ready  output  1.
REQ-007 SHALL have dump stream ports rd_valid  output  1; rd_data  output  8; rd_ready  input  1.
REQ-008 SHALL have core ports core_reset  output  1  active-high reset to core; core_done  input  1  core done flag.
REQ-009 SHALL have memory ports mem_sel  output  1  (1 = sequencer owns dat_mem, 0 = core); mem_wr_en  output  1; mem_addr  output  AW; mem_wdata  output  8; mem_rdata  input  8  (combinational read of mem_addr).
REQ-010 SHALL have status ports busy  output  1; finished  output  1; timeout  output  1; cycle_count  output  16.

Function
REQ-011 SHALL implement states IDLE, LOAD, RUN, DUMP, FIN.
REQ-012 IDLE/FIN: start=1 -> next cycle LOAD if ld_count!=0, else RUN; start ignored in LOAD, RUN, DUMP.
REQ-013 On accepted start: index, cycle_count, timeout cleared; ld_count, dump_base, dump_len latched; later input changes ignored until next start.
REQ-014 LOAD: ld_ready=1; mem_wr_en=ld_valid; mem_addr=index; mem_wdata=ld_data; index increments per beat (ld_valid&ld_ready).
REQ-015 LOAD: beat at index=ld_count-1 -> next cycle RUN, index cleared.
REQ-016 core_reset=0 only in RUN; 1 in all other states, so core restarts at PC 0 every run.
REQ-017 mem_sel=0 only in RUN; 1 otherwise; mem_wr_en=0 outside LOAD.
REQ-018 RUN: cycle_count increments each cycle, saturating at 16'hFFFF.
REQ-019 RUN: core_done sampled from second RUN cycle on; core_done=1 -> next cycle DUMP (or FIN if dump_len=0).
REQ-020 DUMP: rd_valid=1; mem_addr=dump_base+index modulo 2^AW (wrap-around); rd_data=mem_rdata same cycle.
REQ-021 DUMP: index increments per beat (rd_valid&rd_ready); beat at index=dump_len-1 -> next cycle FIN; rd_valid stalls indefinitely while rd_ready=0.
REQ-022 busy=1 in LOAD, RUN, DUMP; finished=1 only in FIN, held until next start.
REQ-023 Sequencer SHALL never write memory outside LOAD and SHALL not clear dat_mem; contents persist across runs.

Reset
REQ-024 reset=0 SHALL immediately force IDLE, index=0, cycle_count=0, timeout=0, regardless of current state.
REQ-025 Output values during/after reset: core_reset=1, mem_sel=1, mem_wr_en=0, ld_ready=0, rd_valid=0, busy=0, finished=0, mem_addr=0, mem_wdata=0, rd_data=mem_rdata.
REQ-026 Reset asserted mid-LOAD or mid-DUMP SHALL abort the transfer with no further memory write or dump beat.

Configuration
REQ-027 Macro RUN_TIMEOUT_EN defined: cycle_count reaching MAX_CYCLES in RUN without core_done -> timeout=1, next cycle DUMP (or FIN if dump_len=0); timeout held until next start or reset.
REQ-028 Macro RUN_TIMEOUT_EN undefined: no limit, RUN waits indefinitely for core_done; timeout tied 0; MAX_CYCLES unused.
REQ-029 core_done and timeout condition in same cycle SHALL count as done: timeout stays 0.

Verification
REQ-030 start, ld_count=3, bytes 8'h11,8'h22,8'h33 with ld_valid=1 -> mem writes addr 0,1,2; RUN on 4th cycle after start; core_reset falls same cycle.
REQ-031 RUN, core_done=1 after 10 cycles, dump_base=8'hFE, dump_len=4 -> mem_addr sequence FE,FF,00,01; cycle_count=10; then FIN, finished=1.
REQ-032 ld_valid toggled 1/0 every cycle, ld_count=4 -> exactly 4 writes at addr 0..3; dump with rd_ready=0 for 5 cycles -> rd_valid held, index unchanged.
REQ-033 ld_count=0, dump_len=0 -> start goes to RUN; core_done -> FIN directly, rd_valid never 1.
REQ-034 RUN_TIMEOUT_EN, MAX_CYCLES=16, core_done=0 -> timeout=1 after 16 RUN cycles, DUMP entered; undefined -> still RUN after 100 cycles.
REQ-035 reset=0 during second DUMP beat -> same-cycle IDLE outputs per REQ-025; start during RUN ignored.
